spawn_scheduler: RTL

//  Shares one 10-bit XNOR LFSR between NUM_LANES obstacle lanes. Lanes request a random draw.
//  A round-robin arbiter grants at most one lane per cycle and returns that lane's LFSR value.

---
 rtl/spawn_pkg.sv | 46 ++++
 rtl/spawn_lfsr.sv | 36 +++
 rtl/spawn_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/spawn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_pkg
//  Description : Shared types, constants and the round-robin pick helper for
//                the spawn scheduler (LFSR geometry, lane index type).
//  Revision    : 1.0 - initial release
// ============================================================================
package spawn_pkg;

  // Random source geometry: 10-bit XNOR LFSR, feedback from bits 9 and 6.
  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;

  // Lane indices are sized for the largest supported lane count so the
  // index type can live in the package, independent of any one instance.
  localparam int MAX_LANES  = 8;
  localparam int LANE_IDX_W = $clog2(MAX_LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef struct packed {
    logic      found;
    lane_idx_t idx;
  } rr_pick_t;

  // First set bit of req, searching upward from ptr and wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_LANES-1:0] req,
                                       input lane_idx_t            ptr,
                                       input int                   n);
    rr_pick_t r;
    int       j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      j = (int'(ptr) + i) % n;
      if ((i < n) && !r.found && req[lane_idx_t'(j)]) begin
        r.found = 1'b1;
        r.idx   = lane_idx_t'(j);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_lfsr
//  Description : 10-bit XNOR LFSR. Resets to all-zero, which is a legal state
//                for XNOR feedback; the all-ones lock-up state is unreachable.
//  Ports       : clk   - clock
//                reset - synchronous active-high reset
//                clear - synchronous clear (same effect as reset)
//                step  - advance one state this cycle
//                q     - current LFSR value
//  Revision    : 1.0 - initial release
// ============================================================================
module spawn_lfsr
  import spawn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_q <= '0;
    end else if (step) begin
      r_q <= {r_q[LFSR_W-2:0], ~(r_q[TAP_HI] ^ r_q[TAP_LO])};
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_scheduler
//  Description : Round-robin arbiter sharing one LFSR between obstacle lanes.
//                Each grant returns the LFSR value (pre-step) and a spawn flag
//                (rand_val < THRESH), one cycle after arbitration.
//  Ports       : clk      - clock
//                reset    - synchronous active-high reset
//                res      - game restart, same clearing effect as reset
//                en       - scheduling enable; 0 freezes grants and LFSR
//                req      - level request per lane
//                gnt      - one-hot grant pulse
//                rand_val - random word for the granted lane
//                spawn    - spawn decision for the granted lane
//  Options     : SPAWN_HOLDOFF_EN - per-lane cooldown of HOLDOFF_CYC cycles
//                after a grant that spawned
//  Revision    : 1.0 - initial release
// ============================================================================
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int THRESH      = 256,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 res,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] req,
  output logic [NUM_LANES-1:0] gnt,
  output logic [LFSR_W-1:0]    rand_val,
  output logic                 spawn
);

  // One extra bit so THRESH = 2**LFSR_W (always spawn) is representable.
  localparam logic [LFSR_W:0] c_thresh = THRESH[LFSR_W:0];

  logic [NUM_LANES-1:0] r_gnt;
  logic [LFSR_W-1:0]    r_rand;
  logic                 r_spawn;
  lane_idx_t            r_ptr;

  logic [NUM_LANES-1:0] w_cool_mask;
  logic [NUM_LANES-1:0] w_elig;
  logic [MAX_LANES-1:0] w_elig_ext;
  rr_pick_t             w_pick;
  logic [LFSR_W-1:0]    w_lfsr_q;
  logic                 w_spawn_now;

  // Masking with the current grant pulse stops a lane whose req has not yet
  // dropped from being granted twice in a row.
  assign w_elig      = en ? (req & ~r_gnt & ~w_cool_mask) : '0;
  assign w_elig_ext  = MAX_LANES'(w_elig);
  assign w_pick      = rr_pick(w_elig_ext, r_ptr, NUM_LANES);
  assign w_spawn_now = ({1'b0, w_lfsr_q} < c_thresh);

  // The LFSR advances only on a grant, so each lane draw consumes one state.
  spawn_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .clear (res),
    .step  (w_pick.found),
    .q     (w_lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (reset || res) begin
      r_gnt   <= '0;
      r_rand  <= '0;
      r_spawn <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_gnt <= '0;
      if (w_pick.found) begin
        r_gnt   <= NUM_LANES'(1) << w_pick.idx;
        r_rand  <= w_lfsr_q;
        r_spawn <= w_spawn_now;
        r_ptr   <= (int'(w_pick.idx) == NUM_LANES - 1) ? '0 : w_pick.idx + 1'b1;
      end
    end
  end

`ifdef SPAWN_HOLDOFF_EN
  localparam int c_cnt_w = $clog2(HOLDOFF_CYC + 1);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_cool
    logic [c_cnt_w-1:0] r_cnt;

    // A fresh spawn on this lane reloads the counter even if it was running.
    always_ff @(posedge clk) begin
      if (reset || res) begin
        r_cnt <= '0;
      end else if (w_pick.found && w_spawn_now && (w_pick.idx == lane_idx_t'(g))) begin
        r_cnt <= c_cnt_w'(HOLDOFF_CYC);
      end else if (en && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_cool_mask[g] = (r_cnt != '0);
  end
`else
  logic w_unused_holdoff;
  assign w_unused_holdoff = (HOLDOFF_CYC != 0);
  assign w_cool_mask      = '0;
`endif

  assign gnt      = r_gnt;
  assign rand_val = r_rand;
  assign spawn    = r_spawn;

endmodule
`default_nettype wire
